seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
//
// PURPOSE
// - Consumer end of the display refresh path. Takes the wrap strobe from the refresh counter
//   (tick) and scans N_DIG multiplexed 7-segment digits: active-low anodes plus hex-decoded
//   active-low segments.
// - Dead-time blanking between digits prevents ghosting.
// - New display words are double-buffered and committed only at frame boundaries, so a frame
//   never shows mixed data.
//
// PARAMETERS
// - N_DIG      4  number of digits; digit N_DIG-1 is most significant; N_DIG >= 2
// - BLANK_CYC  2  Clk_signal cycles with all anodes off between digits; BLANK_CYC >= 1
// - IDX_W      localparam = $clog2(N_DIG)
//
// PORTS
// - Clk_signal  in   1         system clock
// - Reset       in   1         asynchronous, active-high reset
// - tick        in   1         1-cycle advance strobe (refresh-counter wrap pulse)
// - wr_en       in   1         1-cycle write strobe for data_in
// - data_in     in   4*N_DIG   nibble k = data_in[4k+3:4k] = value of digit k
// - anode_n     out  N_DIG     active-low digit enables, one-hot-low or all ones
// - seg_n       out  7         active-low segments; seg_n[0]=a ... seg_n[6]=g
// - digit_idx   out  IDX_W     digit currently selected
// - frame_done  out  1         1-cycle pulse at every frame boundary
//
// BEHAVIOUR
// - Reset (asynchronous): state=IDLE, digit_idx=0, disp_reg=0, pend_reg=0, pend_flag=0,
//   blank_cnt=0, frame_done=0, anode_n=all 1, seg_n=7'h7F.
// - Outputs anode_n and seg_n are decoded only from registered state, digit_idx and disp_reg.
//   They change on the same edge as the state; no input-to-output combinational path.
// - FSM:
//   - IDLE: display dark. On tick -> BLANK with next_idx=0.
//   - SHOW: anode_n[digit_idx]=0; seg_n=hex(disp_reg nibble digit_idx).
//     On tick -> BLANK with next_idx = (digit_idx==N_DIG-1) ? 0 : digit_idx+1.
//   - BLANK: anode_n=all 1, seg_n=7'h7F; blank_cnt counts 0..BLANK_CYC-1.
//     At blank_cnt==BLANK_CYC-1 -> SHOW, blank_cnt cleared.
//     Any tick received while in BLANK is ignored; it is not queued.
// - digit_idx loads next_idx on the edge that enters BLANK.
//   Latency: tick in SHOW to the next digit lit = BLANK_CYC+1 edges.
// - Frame boundary = the edge entering BLANK with next_idx==0. This includes the first
//   tick out of IDLE.
//   - frame_done=1 for exactly that one cycle.
//   - If pend_flag is set: disp_reg<=pend_reg and pend_flag<=0.
// - wr_en: pend_reg<=data_in and pend_flag<=1. Last write before a boundary wins.
// - wr_en on the same edge as a boundary:
//   - disp_reg takes the old pend_reg, and only if pend_flag was already set.
//   - pend_reg takes data_in and pend_flag ends at 1.
//   - The new value is committed at the next boundary.
// - Hex decode (seg_n, gfedcba, active-low):
//   0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//   8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110
// - Reset asserted mid-frame forces IDLE immediately and discards pending data.
//   After release, nothing is lit until the next tick.
//
// CONFIGURATION
// - LEAD_ZERO_BLANK_EN defined:
//   - A digit k>0 is suppressed when disp_reg nibbles k..N_DIG-1 are all 0.
//   - A suppressed digit in SHOW drives anode_n=all 1 and seg_n=7'h7F.
//   - Digit 0 is never suppressed. FSM timing, digit_idx and frame_done are unchanged.
// - LEAD_ZERO_BLANK_EN undefined: every digit is always shown, including leading zeros.
//
// TESTING
// - Reset, then 5 idle clocks -> anode_n=4'b1111, seg_n=7'h7F, frame_done=0, digit_idx=0.
// - wr_en with data_in=16'h12AF, then ticks every 8 clocks:
//   - frame_done pulses on the first tick.
//   - Digits scan 0,1,2,3,0 with seg F=0001110, A=0001000, 2=0100100, 1=1111001.
//   - anode_n=1110,1101,1011,0111.
//   - Exactly 2 dark cycles before each digit.
// - wr_en 16'h0008 mid-frame while 16'h12AF is shown -> rest of the frame still shows 12AF;
//   8 is shown from the boundary onward.
// - wr_en on the same cycle as a boundary, pend empty -> disp unchanged that frame and
//   committed next frame. Tick during BLANK -> ignored, scan order unchanged.
// - Reset pulsed while digit 2 is lit -> same cycle anode_n=1111 and state IDLE.
//   First post-reset tick lights digit 0 with value 0 (1000000).
// - LEAD_ZERO_BLANK_EN with disp=16'h0050 -> digits 0 and 1 lit (0, 5); digits 2 and 3 dark;
//   frame_done period unchanged.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with dead-time blanking
// and frame-synchronous double-buffered display data.
//
// Ports:
//   Clk_signal  system clock
//   Reset       asynchronous, active-high reset
//   tick        1-cycle advance strobe from the refresh counter
//   wr_en       1-cycle write strobe for data_in
//   data_in     nibble k = value of digit k (digit N_DIG-1 is MSD)
//   anode_n     active-low digit enables, one-hot-low or all ones
//   seg_n       active-low segments, seg_n[0]=a ... seg_n[6]=g
//   digit_idx   digit currently selected
//   frame_done  1-cycle pulse on every frame boundary
//
// Optional build macro: LEAD_ZERO_BLANK_EN suppresses leading zeros.
module seg7_scan_driver #(
  parameter  int N_DIG     = 4,
  parameter  int BLANK_CYC = 2,
  localparam int IDX_W     = $clog2(N_DIG)
) (
  input  logic               Clk_signal,
  input  logic               Reset,
  input  logic               tick,
  input  logic               wr_en,
  input  logic [4*N_DIG-1:0] data_in,
  output logic [N_DIG-1:0]   anode_n,
  output logic [6:0]         seg_n,
  output logic [IDX_W-1:0]   digit_idx,
  output logic               frame_done
);

  localparam int CNT_W =
    (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(N_DIG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4*N_DIG-1:0] disp_q, disp_d;
  logic [4*N_DIG-1:0] pend_q, pend_d;
  logic               pflag_q, pflag_d;
  logic               fd_q, fd_d;
  logic [N_DIG-1:0]   anode_q, anode_d;
  logic [6:0]         seg_q, seg_d;
  logic               bound;
  logic               supp_d;

  function automatic logic [3:0] nib_sel(
    input logic [4*N_DIG-1:0] d,
    input logic [IDX_W-1:0]   i
  );
    logic [3:0] r;
    r = 4'h0;
    for (int k = 0; k < N_DIG; k++) begin
      if (i == IDX_W'(k)) r = d[4*k +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] hex7(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef LEAD_ZERO_BLANK_EN
  // Digit i>0 is dark when it and every
  // more significant nibble are zero.
  function automatic logic lead_zero(
    input logic [4*N_DIG-1:0] d,
    input logic [IDX_W-1:0]   i
  );
    logic nz;
    nz = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if (k >= int'(i) && d[4*k +: 4] != 4'h0)
        nz = 1'b1;
    end
    return (i != '0) && !nz;
  endfunction

  always_comb begin
    supp_d = lead_zero(disp_d, idx_d);
  end
`else
  assign supp_d = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    fd_d    = 1'b0;
    bound   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          bound   = 1'b1;
        end
      end
      SHOW: begin
        if (tick) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            bound = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      BLANK: begin
        // ticks here are dropped on purpose
        if (cnt_q == CNT_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (bound) begin
      fd_d = 1'b1;
      if (pflag_q) begin
        disp_d  = pend_q;
        pflag_d = 1'b0;
      end
    end

    // A write on a boundary edge lands in
    // pend and waits for the next frame.
    if (wr_en) begin
      pend_d  = data_in;
      pflag_d = 1'b1;
    end
  end

  // Outputs are registered from next-state
  // values so they move with the state.
  always_comb begin
    anode_d = '1;
    seg_d   = 7'h7F;
    if (state_d == SHOW && !supp_d) begin
      anode_d = ~(N_DIG'(1) << idx_d);
      seg_d   = hex7(nib_sel(disp_d, idx_d));
    end
  end

  always_ff @(posedge Clk_signal or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      fd_q    <= 1'b0;
      anode_q <= '1;
      seg_q   <= 7'h7F;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      fd_q    <= fd_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign anode_n    = anode_q;
  assign seg_n      = seg_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: table-driven and scoreboard checks
// for the 4-digit seg7_scan_driver.
module tb_seg7_scan_driver;

  logic        Clk_signal;
  logic        Reset;
  logic        tick;
  logic        wr_en;
  logic [15:0] data_in;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [1:0] idx;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       fd;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[5];

  logic [6:0] hexs [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_driver #(
    .N_DIG(4),
    .BLANK_CYC(2)
  ) dut (
    .Clk_signal(Clk_signal),
    .Reset(Reset),
    .tick(tick),
    .wr_en(wr_en),
    .data_in(data_in),
    .anode_n(anode_n),
    .seg_n(seg_n),
    .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  initial Clk_signal = 1'b0;
  always #5 Clk_signal = ~Clk_signal;

  task automatic cyc();
    @(posedge Clk_signal);
    #1;
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input int         i,
    input logic [3:0] n,
    input bit         fd,
    input bit         lz
  );
    vec_t v;
    v.idx   = 2'(i);
    v.anode = ~(4'b0001 << i);
    v.seg   = hexs[n];
    v.fd    = fd;
    if (lz && LZB) begin
      v.anode = 4'hF;
      v.seg   = 7'h7F;
    end
    return v;
  endfunction

  // One tick, then 7 more clocks (8 per tick).
  task automatic tick_step(
    input vec_t        v,
    input bit          btick,
    input bit          wr,
    input logic [15:0] wd
  );
    vec_t e;
    sb.push_back(v);
    tick    = 1'b1;
    wr_en   = wr;
    data_in = wd;
    cyc();
    tick  = 1'b0;
    wr_en = 1'b0;
    chk("dark1_anode", 32'(anode_n), 32'hF);
    chk("dark1_seg", 32'(seg_n), 32'h7F);
    chk("dark1_fd", 32'(frame_done), 32'(v.fd));
    chk("dark1_idx", 32'(digit_idx), 32'(v.idx));
    if (btick) tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("dark2_anode", 32'(anode_n), 32'hF);
    chk("dark2_fd", 32'(frame_done), 32'h0);
    cyc();
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL sb_empty: got 0 expected 1");
    end else begin
      e = sb.pop_front();
      chk("lit_anode", 32'(anode_n), 32'(e.anode));
      chk("lit_seg", 32'(seg_n), 32'(e.seg));
      chk("lit_idx", 32'(digit_idx), 32'(e.idx));
      cyc();
      chk("hold_anode", 32'(anode_n), 32'(e.anode));
      chk("hold_idx", 32'(digit_idx), 32'(e.idx));
    end
    repeat (4) cyc();
  endtask

  initial begin
    tbl[0] = '{idx:2'd0, anode:4'b1110,
               seg:7'b0001110, fd:1'b1};
    tbl[1] = '{idx:2'd1, anode:4'b1101,
               seg:7'b0001000, fd:1'b0};
    tbl[2] = '{idx:2'd2, anode:4'b1011,
               seg:7'b0100100, fd:1'b0};
    tbl[3] = '{idx:2'd3, anode:4'b0111,
               seg:7'b1111001, fd:1'b0};
    tbl[4] = '{idx:2'd0, anode:4'b1110,
               seg:7'b0001110, fd:1'b1};

    Reset   = 1'b1;
    tick    = 1'b0;
    wr_en   = 1'b0;
    data_in = 16'h0;
    #2;
    chk("rst_anode", 32'(anode_n), 32'hF);
    chk("rst_seg", 32'(seg_n), 32'h7F);
    repeat (2) cyc();
    Reset = 1'b0;
    repeat (5) cyc();
    chk("idle_anode", 32'(anode_n), 32'hF);
    chk("idle_seg", 32'(seg_n), 32'h7F);
    chk("idle_fd", 32'(frame_done), 32'h0);
    chk("idle_idx", 32'(digit_idx), 32'h0);

    // tick ignored test needs nothing pending yet
    wr_en   = 1'b1;
    data_in = 16'h12AF;
    cyc();
    wr_en = 1'b0;
    chk("wr_no_light", 32'(anode_n), 32'hF);
    cyc();

    for (int i = 0; i < 5; i++)
      tick_step(tbl[i], 1'b0, 1'b0, 16'h0);

    // mid-frame write, digit 0 of frame 2 lit
    wr_en   = 1'b1;
    data_in = 16'h0008;
    cyc();
    wr_en = 1'b0;
    tick_step(mk(1, 4'hA, 0, 0), 0, 0, 16'h0);
    tick_step(mk(2, 4'h2, 0, 0), 0, 0, 16'h0);
    tick_step(mk(3, 4'h1, 0, 0), 0, 0, 16'h0);
    tick_step(mk(0, 4'h8, 1, 0), 0, 0, 16'h0);
    tick_step(mk(1, 4'h0, 0, 1), 0, 0, 16'h0);
    tick_step(mk(2, 4'h0, 0, 1), 0, 0, 16'h0);
    tick_step(mk(3, 4'h0, 0, 1), 0, 0, 16'h0);

    // write on boundary edge, nothing pending
    tick_step(mk(0, 4'h8, 1, 0), 0, 1, 16'h3456);
    // extra tick during BLANK is dropped
    tick_step(mk(1, 4'h0, 0, 1), 1, 0, 16'h0);
    tick_step(mk(2, 4'h0, 0, 1), 0, 0, 16'h0);
    tick_step(mk(3, 4'h0, 0, 1), 0, 0, 16'h0);
    tick_step(mk(0, 4'h6, 1, 0), 0, 0, 16'h0);
    tick_step(mk(1, 4'h5, 0, 0), 0, 0, 16'h0);
    tick_step(mk(2, 4'h4, 0, 0), 0, 0, 16'h0);

    // pending write, then reset while digit 2 lit
    wr_en   = 1'b1;
    data_in = 16'h9999;
    cyc();
    wr_en = 1'b0;
    chk("pre_rst_anode", 32'(anode_n), 32'hB);
    Reset = 1'b1;
    #1;
    chk("arst_anode", 32'(anode_n), 32'hF);
    chk("arst_seg", 32'(seg_n), 32'h7F);
    chk("arst_idx", 32'(digit_idx), 32'h0);
    chk("arst_fd", 32'(frame_done), 32'h0);
    cyc();
    Reset = 1'b0;
    repeat (3) cyc();
    chk("post_rst_dark", 32'(anode_n), 32'hF);
    tick_step(mk(0, 4'h0, 1, 0), 0, 0, 16'h0);

    // leading-zero frame with 0050
    wr_en   = 1'b1;
    data_in = 16'h0050;
    cyc();
    wr_en = 1'b0;
    tick_step(mk(1, 4'h0, 0, 1), 0, 0, 16'h0);
    tick_step(mk(2, 4'h0, 0, 1), 0, 0, 16'h0);
    tick_step(mk(3, 4'h0, 0, 1), 0, 0, 16'h0);
    tick_step(mk(0, 4'h0, 1, 0), 0, 0, 16'h0);
    tick_step(mk(1, 4'h5, 0, 0), 0, 0, 16'h0);
    tick_step(mk(2, 4'h0, 0, 1), 0, 0, 16'h0);
    tick_step(mk(3, 4'h0, 0, 1), 0, 0, 16'h0);
    tick_step(mk(0, 4'h0, 1, 0), 0, 0, 16'h0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
